// File: rtl/d_grf_sb_if.sv
// Register-file bus: two write ports, two read ports, issue handshake and scoreboard status.
interface d_grf_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              we0;
  logic [ADDR_W-1:0] wa0;
  logic [DATA_W-1:0] wd0;
  logic              we1;
  logic [ADDR_W-1:0] wa1;
  logic [DATA_W-1:0] wd1;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              iss_en;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_rdy;
  logic              busy1;
  logic              busy2;
  logic              sb_err;

  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra1, ra2, iss_en, iss_addr,
    input  rd1, rd2, iss_rdy, busy1, busy2, sb_err
  );

  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra1, ra2, iss_en, iss_addr,
    output rd1, rd2, iss_rdy, busy1, busy2, sb_err
  );
endinterface

// File: rtl/d_grf_sb.sv
// Decode-stage register file with two prioritised write ports and a pending-write scoreboard.
// Define GRF_BYPASS_EN to forward same-cycle write data and retires onto the read ports.
module d_grf_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 2
) (
  input logic         clk,
  input logic         reset,
  d_grf_sb_if.slave   bus
);
  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];
  logic [CNT_W-1:0]  cnt_q  [Depth];
  logic [CNT_W-1:0]  cnt_d  [Depth];
  logic              err_q, err_d;
  logic              ret0, ret1, iss_ok, iss_take;

  // Number of write ports retiring to address a this cycle.
  function automatic logic [1:0] hits(input logic [ADDR_W-1:0] a, input logic r0,
                                      input logic [ADDR_W-1:0] w0, input logic r1,
                                      input logic [ADDR_W-1:0] w1);
    return 2'(r0 && (w0 == a)) + 2'(r1 && (w1 == a));
  endfunction

  assign ret0 = bus.we0 && (bus.wa0 != '0);
  assign ret1 = bus.we1 && (bus.wa1 != '0);

  // A full counter still accepts an issue if a retire frees a slot this cycle.
  assign iss_ok = (bus.iss_addr == '0) || (cnt_q[bus.iss_addr] != CntMax) ||
                  (hits(bus.iss_addr, ret0, bus.wa0, ret1, bus.wa1) != 2'd0);
  assign iss_take    = bus.iss_en && iss_ok && (bus.iss_addr != '0);
  assign bus.iss_rdy = iss_ok;
  assign bus.sb_err  = err_q;

  always_comb begin
    logic [CNT_W:0] sum;
    logic [1:0]     dec;
    sum    = '0;
    dec    = '0;
    regs_d = regs_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    for (int i = 1; i < Depth; i++) begin
      sum = {1'b0, cnt_q[i]} + (CNT_W+1)'(iss_take && (bus.iss_addr == ADDR_W'(i)));
      dec = hits(ADDR_W'(i), ret0, bus.wa0, ret1, bus.wa1);
      if ((CNT_W+1)'(dec) > sum) begin
        cnt_d[i] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[i] = CNT_W'(sum - (CNT_W+1)'(dec));
      end
    end
    // Port 1 first so port 0 wins an address collision.
    if (ret1) regs_d[bus.wa1] = bus.wd1;
    if (ret0) regs_d[bus.wa0] = bus.wd0;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    bus.rd1   = regs_q[bus.ra1];
    bus.rd2   = regs_q[bus.ra2];
    bus.busy1 = (bus.ra1 != '0) && (cnt_q[bus.ra1] != '0);
    bus.busy2 = (bus.ra2 != '0) && (cnt_q[bus.ra2] != '0);
`ifdef GRF_BYPASS_EN
    if (bus.ra1 != '0) begin
      if (ret0 && (bus.wa0 == bus.ra1))      bus.rd1 = bus.wd0;
      else if (ret1 && (bus.wa1 == bus.ra1)) bus.rd1 = bus.wd1;
    end
    if (bus.ra2 != '0) begin
      if (ret0 && (bus.wa0 == bus.ra2))      bus.rd2 = bus.wd0;
      else if (ret1 && (bus.wa1 == bus.ra2)) bus.rd2 = bus.wd1;
    end
    if ((CNT_W+1)'(hits(bus.ra1, ret0, bus.wa0, ret1, bus.wa1)) >= {1'b0, cnt_q[bus.ra1]})
      bus.busy1 = 1'b0;
    if ((CNT_W+1)'(hits(bus.ra2, ret0, bus.wa0, ret1, bus.wa1)) >= {1'b0, cnt_q[bus.ra2]})
      bus.busy2 = 1'b0;
`endif
  end
endmodule

// File: tb/tb_d_grf_sb.sv
// Directed bench for d_grf_sb: vector table for single-cycle behaviour plus scoreboard,
// underflow, asynchronous-reset and bypass sequences.
module tb_d_grf_sb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  d_grf_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  d_grf_sb #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy1;
    logic        busy2;
    logic        rdy;
    logic        err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic clr();
    bus.we0 = 0; bus.wa0 = 0; bus.wd0 = 0;
    bus.we1 = 0; bus.wa1 = 0; bus.wd1 = 0;
    bus.ra1 = 0; bus.ra2 = 0; bus.iss_en = 0; bus.iss_addr = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Outputs are checked before the edge, so they reflect state from earlier rows.
    vecs[0]  = '{"idle",    0, 0, 0,            0, 0, 0,     0, 31, 0, 0,
                 32'h0,        32'h0,        0, 0, 1, 0};
    vecs[1]  = '{"iss8",    0, 0, 0,            0, 0, 0,     8, 31, 1, 8,
                 32'h0,        32'h0,        0, 0, 1, 0};
    vecs[2]  = '{"busy8",   0, 0, 0,            0, 0, 0,     8, 0,  0, 0,
                 32'h0,        32'h0,        1, 0, 1, 0};
    vecs[3]  = '{"wr8",     1, 8, 32'hDEADBEEF, 0, 0, 0,     1, 2,  0, 0,
                 32'h0,        32'h0,        0, 0, 1, 0};
    vecs[4]  = '{"rd8",     0, 0, 0,            0, 0, 0,     8, 8,  0, 0,
                 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 0};
    vecs[5]  = '{"wr0",     1, 0, 32'h1234,     0, 0, 0,     0, 8,  1, 0,
                 32'h0,        32'hDEADBEEF, 0, 0, 1, 0};
    vecs[6]  = '{"rd0",     0, 0, 0,            0, 0, 0,     0, 0,  0, 0,
                 32'h0,        32'h0,        0, 0, 1, 0};
    vecs[7]  = '{"iss5a",   0, 0, 0,            0, 0, 0,     5, 0,  1, 5,
                 32'h0,        32'h0,        0, 0, 1, 0};
    vecs[8]  = '{"iss5b",   0, 0, 0,            0, 0, 0,     5, 5,  1, 5,
                 32'h0,        32'h0,        1, 1, 1, 0};
    vecs[9]  = '{"wr5both", 1, 5, 32'hA,        1, 5, 32'hB, 8, 6,  0, 0,
                 32'hDEADBEEF, 32'h0,        0, 0, 1, 0};
    vecs[10] = '{"rd5",     0, 0, 0,            0, 0, 0,     5, 5,  0, 0,
                 32'hA,        32'hA,        0, 0, 1, 0};

    clr();
    #12;
    chk("reset_rdy", 32'(bus.iss_rdy), 32'd1);
    chk("reset_err", 32'(bus.sb_err), 32'd0);
    reset = 1'b0;
    cyc();

    for (int i = 0; i < 11; i++) begin
      bus.we0 = vecs[i].we0; bus.wa0 = vecs[i].wa0; bus.wd0 = vecs[i].wd0;
      bus.we1 = vecs[i].we1; bus.wa1 = vecs[i].wa1; bus.wd1 = vecs[i].wd1;
      bus.ra1 = vecs[i].ra1; bus.ra2 = vecs[i].ra2;
      bus.iss_en = vecs[i].iss_en; bus.iss_addr = vecs[i].iss_addr;
      @(negedge clk);
      chk({vecs[i].name, ".rd1"},   bus.rd1,           vecs[i].rd1);
      chk({vecs[i].name, ".rd2"},   bus.rd2,           vecs[i].rd2);
      chk({vecs[i].name, ".busy1"}, 32'(bus.busy1),    32'(vecs[i].busy1));
      chk({vecs[i].name, ".busy2"}, 32'(bus.busy2),    32'(vecs[i].busy2));
      chk({vecs[i].name, ".rdy"},   32'(bus.iss_rdy),  32'(vecs[i].rdy));
      chk({vecs[i].name, ".err"},   32'(bus.sb_err),   32'(vecs[i].err));
      cyc();
    end

    // Fill register 9 to the counter limit; the fourth issue must be refused.
    for (int k = 0; k < 4; k++) begin
      clr(); bus.iss_en = 1; bus.iss_addr = 9; bus.ra1 = 9;
      @(negedge clk);
      chk($sformatf("iss9_%0d.rdy", k), 32'(bus.iss_rdy), (k < 3) ? 32'd1 : 32'd0);
      chk($sformatf("iss9_%0d.busy", k), 32'(bus.busy1), (k == 0) ? 32'd0 : 32'd1);
      cyc();
    end
    // Retire plus issue at a full counter nets out and stays full.
    clr(); bus.iss_en = 1; bus.iss_addr = 9; bus.we1 = 1; bus.wa1 = 9; bus.wd1 = 32'h99;
    @(negedge clk);
    chk("iss9_ret.rdy", 32'(bus.iss_rdy), 32'd1);
    cyc();
    clr(); bus.iss_en = 1; bus.iss_addr = 9; bus.ra1 = 9;
    @(negedge clk);
    chk("iss9_full.rdy", 32'(bus.iss_rdy), 32'd0);
    chk("iss9_full.busy", 32'(bus.busy1), 32'd1);
    cyc();
    for (int k = 0; k < 3; k++) begin
      clr(); bus.we0 = 1; bus.wa0 = 9; bus.wd0 = 32'h100 + 32'(k);
      cyc();
    end
    clr(); bus.ra1 = 9; bus.ra2 = 9;
    @(negedge clk);
    chk("drain9.busy1", 32'(bus.busy1), 32'd0);
    chk("drain9.busy2", 32'(bus.busy2), 32'd0);
    chk("drain9.rd1", bus.rd1, 32'h102);
    chk("drain9.err", 32'(bus.sb_err), 32'd0);
    cyc();

    // Underflow on register 7 sets a sticky error.
    clr(); bus.we0 = 1; bus.wa0 = 7; bus.wd0 = 32'h7;
    @(negedge clk);
    chk("uf7.err_before", 32'(bus.sb_err), 32'd0);
    cyc();
    clr();
    @(negedge clk);
    chk("uf7.err_set", 32'(bus.sb_err), 32'd1);
    cyc();
    @(negedge clk);
    chk("uf7.err_sticky", 32'(bus.sb_err), 32'd1);
    cyc();

    // Asynchronous reset mid-cycle clears state without waiting for an edge.
    clr(); bus.ra1 = 8;
    #1;
    chk("pre_rst.rd1", bus.rd1, 32'hDEADBEEF);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst.err", 32'(bus.sb_err), 32'd0);
    chk("async_rst.rd1", bus.rd1, 32'h0);
    chk("async_rst.rdy", 32'(bus.iss_rdy), 32'd1);
    bus.we0 = 1; bus.wa0 = 8; bus.wd0 = 32'h77; bus.iss_en = 1; bus.iss_addr = 8;
    cyc();
    reset = 1'b0;
    clr(); bus.ra1 = 8;
    @(negedge clk);
    chk("rst_drop.rd1", bus.rd1, 32'h0);
    chk("rst_drop.busy1", 32'(bus.busy1), 32'd0);
    chk("rst_drop.err", 32'(bus.sb_err), 32'd0);
    cyc();

    // Same-cycle write visibility on register 3 with one pending write.
    clr(); bus.iss_en = 1; bus.iss_addr = 3;
    cyc();
    clr(); bus.we0 = 1; bus.wa0 = 3; bus.wd0 = 32'h55; bus.ra1 = 3;
    @(negedge clk);
`ifdef GRF_BYPASS_EN
    chk("byp3.rd1", bus.rd1, 32'h55);
    chk("byp3.busy1", 32'(bus.busy1), 32'd0);
`else
    chk("byp3.rd1", bus.rd1, 32'h0);
    chk("byp3.busy1", 32'(bus.busy1), 32'd1);
`endif
    cyc();
    clr(); bus.ra1 = 3;
    @(negedge clk);
    chk("post3.rd1", bus.rd1, 32'h55);
    chk("post3.busy1", 32'(bus.busy1), 32'd0);
    chk("post3.err", 32'(bus.sb_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
